fifo_rd_stream: RTL and testbench

Read-side consumer for async_fifo, living entirely in the FIFO's read-clock domain. Pops words through the FIFO's has_data/rd_en/rd_data port, which has 1-cycle read latency, and re-presents them as a registered valid/ready stream. A small prefetch buffer sustains one beat per cycle under backpressure without losing words or over-reading.

---
 rtl/fifo_rd_stream_pkg.sv | 15 +
 rtl/fifo_rd_stream_buf.sv | 61 ++++++
 rtl/fifo_rd_stream.sv | 83 ++++++++
 tb/tb_fifo_rd_stream.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream shared sizing helpers.
// Widths for occupancy, pointers and statistics counters.
package fifo_rd_stream_pkg;

  localparam int STATS_W = 32;

  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_buf.sv
// fifo_rd_stream prefetch buffer: circular storage,
// wr/rd pointers and occupancy, with synchronous flush.
module fifo_rd_stream_buf
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  localparam int OW = occ_width(BUF_DEPTH),
  localparam int PW = ptr_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic [OW-1:0]         occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_data = mem[rd_ptr];

  // Storage write on capture; cleared on reset so m_data starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else if (capture && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (capture) wr_ptr <= nxt(wr_ptr);
      if (pop)     rd_ptr <= nxt(rd_ptr);
      unique case (1'b1)
        capture && !pop: occ <= occ + 1'b1;
        pop && !capture: occ <= occ - 1'b1;
        default:         occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: async_fifo read port to registered valid/ready.
// Optional FIFO_RD_STREAM_STATS_EN adds beat/stall counters.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_has_data,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
`ifdef FIFO_RD_STREAM_STATS_EN
  output logic [STATS_W-1:0]    beat_count,
  output logic [STATS_W-1:0]    stall_count,
`endif
  output logic                  busy
);

  localparam int OW = occ_width(BUF_DEPTH);
  localparam int CW = OW + 1;

  logic [OW-1:0] occ;
  logic [CW-1:0] pending;
  logic          inflight;
  logic          capture;
  logic          pop;

  assign pending = CW'(occ) + CW'(inflight);
  assign fifo_rd_en = rst_n & fifo_has_data & ~flush
                    & (pending < CW'(BUF_DEPTH));
  assign capture = inflight & ~flush;
  assign m_valid = (occ != '0);
  assign pop     = m_valid & m_ready;
  assign busy    = m_valid | inflight;

  // One-cycle read latency tracker; flush forces rd_en low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fifo_rd_en;
  end

  fifo_rd_stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .capture   (capture),
    .wr_data   (fifo_rd_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STATS_W-1:0] beat_q;
  logic [STATS_W-1:0] stall_q;

  assign beat_count  = beat_q;
  assign stall_count = stall_q;

  // Saturating beat and stall counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      stall_q <= '0;
    end else begin
      if (pop && beat_q != '1)
        beat_q <= beat_q + 1'b1;
      if (m_valid && !m_ready && stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with an async_fifo read model.
// Define FIFO_RD_STREAM_STATS_EN to also exercise the counters.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_has_data;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       flush;
  logic       busy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] beat_count;
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] mem_m [256];
  int  wp = 0;
  int  rp = 0;
  bit  hd_en = 1'b0;
  bit  hd_ovr = 1'b0;
  logic [7:0] delivered [$];

  fifo_rd_stream #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (3)
  ) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_has_data (fifo_has_data),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .flush         (flush),
`ifdef FIFO_RD_STREAM_STATS_EN
    .beat_count    (beat_count),
    .stall_count   (stall_count),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  assign fifo_has_data = hd_ovr | (hd_en & (wp != rp));

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem_m[rp[7:0]];
      rp <= rp + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_n && m_valid && m_ready) delivered.push_back(m_data);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (u_dut.occ <= 2'd3) else begin
        failures++;
        $error("FAIL occ_bound observed=%0d expected<=3", u_dut.occ);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      mem_m[wp[7:0]] = 8'(base + i);
      wp = wp + 1;
    end
  endtask

  task automatic expect_stream(input string tag, input int first,
                               input int n);
    int w = 0;
    while (!m_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_start"}, 32'(m_valid), 32'd1);
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(m_valid), 32'd1);
      check({tag, "_data"}, 32'(m_data), 32'(8'(first + i)));
      @(negedge clk);
    end
  endtask

  initial begin
    int s;
    rst_n = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    hd_en = 1'b1;
    hd_ovr = 1'b1;

    // 1: reset holds rd_en low even with has_data high
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    hd_ovr = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_rd_en", 32'(fifo_rd_en), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // 2: full-rate stream, latency T+2
    m_ready = 1'b1;
    preload(0, 16);
    #1;
    check("t2_rd_en_T", 32'(fifo_rd_en), 32'd1);
    check("t2_valid_T", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_T1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_T2", 32'(m_valid), 32'd1);
    expect_stream("t2", 0, 16);
    check("t2_drained_valid", 32'(m_valid), 32'd0);
    check("t2_drained_busy", 32'(busy), 32'd0);

    // 3: backpressure fills buffer with exactly 3 pops
    m_ready = 1'b0;
    preload(0, 16);
    repeat (8) @(negedge clk);
    check("t3_pops", 32'(rp), 32'd19);
    check("t3_valid", 32'(m_valid), 32'd1);
    check("t3_data", 32'(m_data), 32'd0);
    check("t3_rd_en", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    expect_stream("t3", 0, 16);
    check("t3_busy", 32'(busy), 32'd0);

    // 4: flush with one word in flight
    m_ready = 1'b0;
    preload(0, 16);
    repeat (8) @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    check("t4_refill", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    check("t4_inflight", 32'(u_dut.inflight), 32'd1);
    flush = 1'b1;
    #1;
    check("t4_flush_rd_en", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("t4_valid", 32'(m_valid), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_pops", 32'(rp), 32'd36);
    m_ready = 1'b1;
    expect_stream("t4", 4, 12);

    // 5: has_data toggling with random backpressure
    repeat (4) @(negedge clk);
    s = delivered.size();
    preload(8'hA0, 16);
    for (int c = 0; c < 60; c++) begin
      hd_en = ((c / 6) % 2) == 0;
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    hd_en = 1'b1;
    m_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("t5_pops", 32'(rp), 32'd64);
    check("t5_count", 32'(delivered.size() - s), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (s + i < delivered.size())
        check("t5_order", 32'(delivered[s + i]), 32'(8'hA0 + i));
      else
        check("t5_missing", 32'd0, 32'd1);
    end
    check("t5_busy", 32'(busy), 32'd0);

`ifdef FIFO_RD_STREAM_STATS_EN
    // 6: counters, then beat saturation
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b0;
    check("t6_beat_rst", beat_count, 32'd0);
    preload(0, 16);
    s = 0;
    while (!m_valid && s < 20) begin
      @(negedge clk);
      s++;
    end
    repeat (5) @(negedge clk);
    m_ready = 1'b1;
    repeat (25) @(negedge clk);
    check("t6_beats", beat_count, 32'd16);
    check("t6_stalls", stall_count, 32'd5);
    force u_dut.beat_q = 32'hFFFF_FFFD;
    @(negedge clk);
    release u_dut.beat_q;
    preload(0, 4);
    repeat (12) @(negedge clk);
    check("t6_saturate", beat_count, 32'hFFFF_FFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
